tiny_cpu_mc: RTL and testbench

Multi-cycle, parametrised successor of the single-cycle tiny CPU. It executes the same 8-bit instruction encoding from either an external valid/ready instruction stream or an internal sync-read instruction memory. It adds a program counter, jump, branch-on-zero, halt and registered result output. It sits at the top of the processor datapath and reuses the existing `ALU` and `RegisterFile` blocks.

---
 rtl/tiny_cpu_pkg.sv | 47 ++++
 rtl/tiny_cpu_lib.sv | 65 ++++++
 rtl/tiny_imem.sv | 23 ++
 rtl/tiny_cpu_mc.sv | 179 +++++++++++++++++
 tb/tb_tiny_cpu_mc.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared encodings, FSM states and instruction decode for the multi-cycle tiny CPU.
package tiny_cpu_pkg;

    localparam logic [1:0] OP_LI   = 2'b10;
    localparam logic [5:0] OP_OUT  = 6'b1111_00;
    localparam logic [5:0] OP_JMP  = 6'b1111_01;
    localparam logic [5:0] OP_BZ   = 6'b1111_10;
    localparam logic [5:0] OP_MODE = 6'b1111_11;

    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [1:0] R_DST    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        I_ALU,
        I_LI,
        I_OUT,
        I_JMP,
        I_BZ,
        I_MODE
    } iclass_t;

    function automatic iclass_t decode(input logic [7:0] ir);
        iclass_t c;
        c = I_ALU;
        if (ir[7:6] == OP_LI) begin
            c = I_LI;
        end else begin
            case (ir[7:2])
                OP_OUT:  c = I_OUT;
                OP_JMP:  c = I_JMP;
                OP_BZ:   c = I_BZ;
                OP_MODE: c = I_MODE;
                default: c = I_ALU;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/tiny_cpu_lib.sv
// Datapath building blocks shared with the single-cycle CPU: ALU, 4-entry register file, imm4 sign extension.
module ALU #(
    parameter int WORDSIZE = 8
) (
    input  logic [3:0]          aluc,
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic                cin,
    output logic [WORDSIZE-1:0] y,
    output logic                zero
);
    always_comb begin
        y = '0;
        case (aluc)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: y = a + b + WORDSIZE'(cin);
            4'b0011: y = a ^ b;
            4'b0100: y = a << 1;
            4'b0101: y = a >> 1;
            4'b0110: y = a - b;
            4'b0111: y = WORDSIZE'($signed(a) < $signed(b));
            4'b1100: y = ~(a | b);
            4'b1101: y = ~(a & b);
            4'b1110: y = a;
            default: y = '0;
        endcase
        zero = (y == '0);
    end
endmodule

module RegisterFile #(
    parameter int WORDSIZE = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [1:0]          waddr,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic [1:0]          raddr_a,
    input  logic [1:0]          raddr_b,
    output logic [WORDSIZE-1:0] rdata_a,
    output logic [WORDSIZE-1:0] rdata_b
);
    logic [WORDSIZE-1:0] regs_q [4];

    always_ff @(posedge clk) begin
        if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
    end
endmodule

module SignExtend #(
    parameter int WORDSIZE = 8
) (
    input  logic [3:0]          in4,
    output logic [WORDSIZE-1:0] out
);
    always_comb out = WORDSIZE'($signed(in4));
endmodule

// File: rtl/tiny_imem.sv
// Instruction memory: one synchronous write port, one synchronous read port; a same-address collision reads the old word.
module tiny_imem #(
    parameter int IMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] waddr,
    input  logic [7:0]                    wdata,
    input  logic [$clog2(IMEM_DEPTH)-1:0] raddr,
    output logic [7:0]                    rdata
);
    logic [7:0] mem_q [IMEM_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    always_comb rdata = rdata_q;
endmodule

// File: rtl/tiny_cpu_mc.sv
// Multi-cycle tiny CPU: executes 8-bit instructions from a valid/ready stream or from the internal instruction memory.
module tiny_cpu_mc
    import tiny_cpu_pkg::*;
#(
    parameter int WORDSIZE   = 8,
    parameter int IMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    instr,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [7:0]                    imem_wdata,
    output logic [WORDSIZE-1:0]           res,
    output logic                          res_valid,
    output logic                          mode,
    output logic                          busy
);
    localparam int PCW = $clog2(IMEM_DEPTH);

    state_t              state_q, state_d;
    logic [PCW-1:0]      pc_q, pc_d;
    logic                zf_q, zf_d;
    logic                mode_q, mode_d;
    logic [7:0]          ir_q, ir_d;
    logic [WORDSIZE-1:0] vale_q, vale_d;
    logic [WORDSIZE-1:0] res_q, res_d;
    logic                res_valid_q, res_valid_d;

    iclass_t             iclass;
    logic                writes_reg;
    logic [7:0]          imem_rdata;
    logic [WORDSIZE-1:0] rf_a, rf_b, sext_imm;
    logic [WORDSIZE-1:0] alu_a, alu_b, alu_y;
    logic [3:0]          alu_op;
    logic                alu_zero;
    logic                rf_we;
    logic [1:0]          rf_waddr;

    tiny_imem #(.IMEM_DEPTH(IMEM_DEPTH)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q),
        .rdata (imem_rdata)
    );

    RegisterFile #(.WORDSIZE(WORDSIZE)) u_rf (
        .clk     (clk),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (vale_q),
        .raddr_a (ir_q[3:2]),
        .raddr_b (ir_q[1:0]),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    SignExtend #(.WORDSIZE(WORDSIZE)) u_sext (
        .in4 (ir_q[3:0]),
        .out (sext_imm)
    );

    ALU #(.WORDSIZE(WORDSIZE)) u_alu (
        .aluc (alu_op),
        .a    (alu_a),
        .b    (alu_b),
        .cin  (1'b0),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // LI reuses the ALU as sext(imm) + 0 so zf follows the same path as R-type.
    always_comb begin
        iclass     = decode(ir_q);
        writes_reg = (iclass == I_ALU) || (iclass == I_LI);
        alu_a      = (iclass == I_LI) ? sext_imm : rf_a;
        alu_b      = (iclass == I_LI) ? '0 : rf_b;
        alu_op     = (iclass == I_LI) ? ALUC_ADD : ir_q[7:4];
        rf_waddr   = (iclass == I_LI) ? ir_q[5:4] : R_DST;
        rf_we      = (state_q == S_WB) && writes_reg && !rst;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        zf_d        = zf_q;
        mode_d      = mode_q;
        ir_d        = ir_q;
        vale_d      = vale_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        instr_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = !mode_q;
                if (mode_q) begin
                    state_d = S_FETCH;
                end else if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_EXEC;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Non-ALU instructions carry r[ss] through valE to the WB stage.
                vale_d = writes_reg ? alu_y : rf_b;
                if (writes_reg) begin
                    zf_d = alu_zero;
                end
                state_d = S_WB;
            end
            S_WB: begin
                case (iclass)
                    I_OUT: begin
                        res_d       = vale_q;
                        res_valid_d = 1'b1;
                        if (mode_q) pc_d = pc_q + PCW'(1);
                    end
                    I_JMP: begin
                        if (mode_q) pc_d = vale_q[PCW-1:0];
                    end
                    I_BZ: begin
                        if (mode_q) pc_d = zf_q ? vale_q[PCW-1:0] : pc_q + PCW'(1);
                    end
                    I_MODE: begin
                        if (!mode_q) begin
                            mode_d = 1'b1;
                            pc_d   = '0;
                        end else begin
                            mode_d = 1'b0;
                        end
                    end
                    default: begin
                        if (mode_q) pc_d = pc_q + PCW'(1);
                    end
                endcase
                state_d = mode_d ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            zf_q        <= 1'b0;
            mode_q      <= 1'b0;
            ir_q        <= '0;
            vale_q      <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            zf_q        <= zf_d;
            mode_q      <= mode_d;
            ir_q        <= ir_d;
            vale_q      <= vale_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        res       = res_q;
        res_valid = res_valid_q;
        mode      = mode_q;
        busy      = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_tiny_cpu_mc.sv
// Scoreboard bench for tiny_cpu_mc: ISA-level reference model feeds expected OUT values to queues drained by monitors.
module tb_tiny_cpu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   instr = '0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic         imem_we = 1'b0;
    logic [3:0]   imem_waddr = '0;
    logic [7:0]   imem_wdata = '0;
    logic [W-1:0] res;
    logic         res_valid, mode, busy;

    logic [7:0]   instr4 = '0;
    logic         instr_valid4 = 1'b0;
    logic         instr_ready4;
    logic         imem_we4 = 1'b0;
    logic [1:0]   imem_waddr4 = '0;
    logic [7:0]   imem_wdata4 = '0;
    logic [W-1:0] res4;
    logic         res_valid4, mode4, busy4;

    always #5 clk = ~clk;

    tiny_cpu_mc #(.WORDSIZE(W), .IMEM_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .res(res), .res_valid(res_valid), .mode(mode), .busy(busy)
    );

    tiny_cpu_mc #(.WORDSIZE(W), .IMEM_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .instr(instr4), .instr_valid(instr_valid4), .instr_ready(instr_ready4),
        .imem_we(imem_we4), .imem_waddr(imem_waddr4), .imem_wdata(imem_wdata4),
        .res(res4), .res_valid(res_valid4), .mode(mode4), .busy(busy4)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp4_q[$];

    // Architectural model of the 16-deep CPU
    logic [7:0] m_regs [4];
    bit         m_zf   = 1'b0;
    int         m_pc   = 0;
    bit         m_mode = 1'b0;
    logic [7:0] m_imem [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL res_unexpected: got pulse with res=%0h, required no pulse", res);
            end else begin
                check("res", res, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (res_valid4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL res4_unexpected: got pulse with res=%0h, required no pulse", res4);
            end else begin
                check("res4", res4, exp4_q.pop_front());
            end
        end
    end

    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        int r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = int'(a) + int'(b);
            4'd3:    r = a ^ b;
            4'd4:    r = int'(a) * 2;
            4'd5:    r = int'(a) / 2;
            4'd6:    r = int'(a) - int'(b);
            4'd7:    r = (sa < sb) ? 1 : 0;
            4'd12:   r = ~(a | b);
            4'd13:   r = ~(a & b);
            4'd14:   r = a;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic model_step(input logic [7:0] ins);
        logic [7:0] v;
        if (ins[7:6] == 2'b10) begin
            v = {{4{ins[3]}}, ins[3:0]};
            m_regs[ins[5:4]] = v;
            m_zf = (v == 0);
            if (m_mode) m_pc = (m_pc + 1) % 16;
        end else if (ins[7:4] == 4'hF) begin
            case (ins[3:2])
                2'd0: begin
                    exp_q.push_back(m_regs[ins[1:0]]);
                    if (m_mode) m_pc = (m_pc + 1) % 16;
                end
                2'd1: if (m_mode) m_pc = m_regs[ins[1:0]] % 16;
                2'd2: if (m_mode) m_pc = m_zf ? m_regs[ins[1:0]] % 16 : (m_pc + 1) % 16;
                default: begin
                    if (!m_mode) begin
                        m_mode = 1'b1;
                        m_pc = 0;
                    end else begin
                        m_mode = 1'b0;
                    end
                end
            endcase
        end else begin
            v = ref_alu(ins[7:4], m_regs[ins[3:2]], m_regs[ins[1:0]]);
            m_regs[2] = v;
            m_zf = (v == 0);
            if (m_mode) m_pc = (m_pc + 1) % 16;
        end
    endtask

    task automatic model_run_mem(input int max_outs);
        int start = exp_q.size();
        int steps = 0;
        while (m_mode && (exp_q.size() - start) < max_outs && steps < 200) begin
            model_step(m_imem[m_pc]);
            steps++;
        end
    endtask

    task automatic model_reset();
        m_zf = 1'b0;
        m_pc = 0;
        m_mode = 1'b0;
    endtask

    task automatic wait_ready(input int which);
        int budget = 50;
        while (!((which == 0) ? instr_ready : instr_ready4) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: got ready low for 50 cycles, required ready");
        end
    endtask

    task automatic send(input int which, input logic [7:0] ins, input bit do_model);
        @(negedge clk);
        if (which == 0) begin
            instr = ins;
            instr_valid = 1'b1;
        end else begin
            instr4 = ins;
            instr_valid4 = 1'b1;
        end
        wait_ready(which);
        @(posedge clk);
        if (do_model) model_step(ins);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_valid4 = 1'b0;
    endtask

    task automatic imem_write(input int which, input int addr, input logic [7:0] data);
        @(negedge clk);
        if (which == 0) begin
            imem_we = 1'b1;
            imem_waddr = 4'(addr);
            imem_wdata = data;
            m_imem[addr] = data;
        end else begin
            imem_we4 = 1'b1;
            imem_waddr4 = 2'(addr);
            imem_wdata4 = data;
        end
        @(negedge clk);
        imem_we = 1'b0;
        imem_we4 = 1'b0;
    endtask

    task automatic drain(input int which, input int budget);
        int b = budget;
        while (((which == 0) ? exp_q.size() : exp4_q.size()) != 0 && b > 0) begin
            @(posedge clk);
            b--;
        end
        check("drain_pending", (which == 0) ? exp_q.size() : exp4_q.size(), 0);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ins;
        int b;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_res", res, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_mode", mode, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", instr_ready, 1);
        check("rst4_busy", busy4, 0);
        check("rst4_ready", instr_ready4, 1);

        // Stream arithmetic and OUT latency
        send(0, 8'h83, 1);
        send(0, 8'h9E, 1);
        send(0, 8'h21, 1);
        send(0, 8'hF2, 1);
        check("lat_k1_valid", res_valid, 0);
        check("lat_k1_ready", instr_ready, 0);
        @(negedge clk);
        check("lat_k2_valid", res_valid, 0);
        check("lat_k2_ready", instr_ready, 0);
        @(negedge clk);
        check("lat_k3_valid", res_valid, 1);
        check("lat_k3_ready", instr_ready, 1);
        @(negedge clk);
        check("lat_k4_valid", res_valid, 0);
        send(0, 8'hB7, 1);
        drain(0, 50);

        // Backpressure with instr_valid held high
        @(negedge clk);
        instr = 8'h8F;
        instr_valid = 1'b1;
        wait_ready(0);
        @(posedge clk);
        model_step(8'h8F);
        @(negedge clk);
        check("bp_ready_exec", instr_ready, 0);
        instr = 8'hF0;
        @(negedge clk);
        check("bp_ready_wb", instr_ready, 0);
        @(negedge clk);
        check("bp_ready_again", instr_ready, 1);
        @(posedge clk);
        model_step(8'hF0);
        @(negedge clk);
        instr_valid = 1'b0;
        check("bp_ready_exec2", instr_ready, 0);
        drain(0, 50);

        // Reset during EXEC of an OUT, with a simultaneous imem write
        send(0, 8'hF1, 0);
        rst = 1'b1;
        imem_we = 1'b1;
        imem_waddr = 4'd1;
        imem_wdata = 8'hF0;
        m_imem[1] = 8'hF0;
        @(negedge clk);
        rst = 1'b0;
        imem_we = 1'b0;
        model_reset();
        check("midrst_busy", busy, 0);
        check("midrst_mode", mode, 0);
        check("midrst_res", res, 0);
        check("midrst_res_valid", res_valid, 0);
        repeat (4) @(negedge clk);

        // Memory program ending in HALT
        imem_write(0, 0, 8'h85);
        imem_write(0, 2, 8'hFC);
        send(0, 8'hFC, 1);
        model_run_mem(10);
        repeat (2) @(negedge clk);
        check("mem_mode_on", mode, 1);
        check("mem_ready_low", instr_ready, 0);
        b = 100;
        while ((busy || mode) && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("halt_mode", mode, 0);
        check("halt_ready", instr_ready, 1);
        drain(0, 50);

        // Branch-on-zero back to address 0
        imem_write(0, 0, 8'hF2);
        imem_write(0, 1, 8'h81);
        imem_write(0, 2, 8'h9F);
        imem_write(0, 3, 8'hB0);
        imem_write(0, 4, 8'h21);
        imem_write(0, 5, 8'hFB);
        send(0, 8'hFC, 1);
        model_run_mem(3);
        drain(0, 300);
        reset_pulse();
        check("bz_rst_busy", busy, 0);
        check("bz_rst_mode", mode, 0);

        // Randomized stream traffic; MODE excluded to stay in stream mode
        for (int i = 0; i < 150; i++) begin
            ins = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ins = {6'b111100, ins[1:0]};
            if (ins[7:2] == 6'b111111) ins[3:2] = 2'b00;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(0, ins, 1);
        end
        drain(0, 100);

        // PC wrap on the 4-deep instance
        send(1, 8'h81, 0);
        send(1, 8'h92, 0);
        send(1, 8'h21, 0);
        send(1, 8'hB4, 0);
        imem_write(1, 0, 8'hF0);
        imem_write(1, 1, 8'hF1);
        imem_write(1, 2, 8'hF2);
        imem_write(1, 3, 8'hF3);
        exp4_q.push_back(8'd1);
        exp4_q.push_back(8'd2);
        exp4_q.push_back(8'd3);
        exp4_q.push_back(8'd4);
        exp4_q.push_back(8'd1);
        exp4_q.push_back(8'd2);
        send(1, 8'hFC, 0);
        drain(1, 200);
        reset_pulse();
        check("wrap_rst_busy", busy4, 0);
        check("wrap_rst_mode", mode4, 0);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
